// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the data-memory access controller.
package mem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_RD_LAT = 1;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requester owning the current access.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_PNL = 1'b1
    } gnt_t;

    // Registered memory operation, sized to the default widths.
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        gnt_t                  src;
    } op_t;

endpackage

// File: rtl/btn_edge_detect.sv
// Single-bit rising-edge detector for an already-synchronised button.
module btn_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic edge_o
);

    logic btn_q;

    // History clears to 0 so a button held through reset yields one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign edge_o = btn_i & ~btn_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares a single-port data memory between the CPU load/store port and the
// front panel, with round-robin arbitration and fixed read latency.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [DATA_W-1:0] pnl_sw,
    input  logic              pnl_btn_addr,
    input  logic              pnl_btn_write,
    output logic [DATA_W-1:0] pnl_out,
    output logic              pnl_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Last WAIT-cycle count value; WAIT is unused when RD_LAT is 1.
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    gnt_t              last_q, last_d;
    logic              pnd_q, pnd_d;
    logic              pnd_we_q, pnd_we_d;
    logic [ADDR_W-1:0] pnl_addr_q, pnl_addr_d;
    logic [DATA_W-1:0] pnl_wdata_q, pnl_wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] pnl_out_q, pnl_out_d;
    logic              addr_edge, write_edge;
    logic              grant_cpu, grant_pnl;

    btn_edge_detect u_addr_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (pnl_btn_addr),
        .edge_o (addr_edge)
    );

    btn_edge_detect u_write_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (pnl_btn_write),
        .edge_o (write_edge)
    );

    // Round-robin choice; only acted on in IDLE.
    always_comb begin
        grant_cpu = 1'b0;
        grant_pnl = 1'b0;
        if (cpu_req && pnd_q) begin
            if (last_q == GNT_PNL) grant_cpu = 1'b1;
            else                   grant_pnl = 1'b1;
        end else if (cpu_req) begin
            grant_cpu = 1'b1;
        end else if (pnd_q) begin
            grant_pnl = 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_cpu || grant_pnl) state_d = ISSUE;
            ISSUE: begin
                if (op_q.we)         state_d = IDLE;
                else if (RD_LAT > 1) state_d = WAIT;
                else                 state_d = DONE;
            end
            WAIT:    if (cnt_q == WAIT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer outputs; read data bypasses the holding registers in DONE
    // so it is valid alongside the rvalid pulse.
    always_comb begin
        mem_en     = (state_q == ISSUE);
        mem_we     = op_q.we;
        mem_addr   = op_q.addr;
        mem_wdata  = op_q.wdata;
        cpu_ack    = (state_q == ISSUE) && (op_q.src == GNT_CPU);
        cpu_rvalid = (state_q == DONE)  && (op_q.src == GNT_CPU);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        pnl_busy   = pnd_q;
        pnl_out    = pnl_out_q;
        if ((state_q == ISSUE) && (op_q.src == GNT_PNL) && op_q.we) begin
            pnl_out = op_q.wdata;
        end else if ((state_q == DONE) && (op_q.src == GNT_PNL)) begin
            pnl_out = mem_rdata;
        end
    end

    // Datapath next-state: panel capture, grant registration, completion.
    always_comb begin
        op_d        = op_q;
        last_d      = last_q;
        pnd_d       = pnd_q;
        pnd_we_d    = pnd_we_q;
        pnl_addr_d  = pnl_addr_q;
        pnl_wdata_d = pnl_wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        pnl_out_d   = pnl_out_q;

        if (!pnd_q) begin
            if (addr_edge) begin
                pnl_addr_d = ADDR_W'(pnl_sw);
                pnd_d      = 1'b1;
                pnd_we_d   = 1'b0;
            end else if (write_edge) begin
                pnl_wdata_d = pnl_sw;
                pnd_d       = 1'b1;
                pnd_we_d    = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    op_d.we    = cpu_we;
                    op_d.addr  = cpu_addr;
                    op_d.wdata = cpu_wdata;
                    op_d.src   = GNT_CPU;
                    last_d     = GNT_CPU;
                end else if (grant_pnl) begin
                    op_d.we    = pnd_we_q;
                    op_d.addr  = pnl_addr_q;
                    op_d.wdata = pnl_wdata_q;
                    op_d.src   = GNT_PNL;
                    last_d     = GNT_PNL;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if ((op_q.src == GNT_PNL) && op_q.we) begin
                    pnd_d     = 1'b0;
                    pnl_out_d = op_q.wdata;
                end
            end
            WAIT: cnt_d = cnt_q + 2'd1;
            DONE: begin
                if (op_q.src == GNT_CPU) begin
                    cpu_rdata_d = mem_rdata;
                end else begin
                    pnl_out_d = mem_rdata;
                    pnd_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; last grant starts at PANEL so the CPU wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            last_q      <= GNT_PNL;
            pnd_q       <= 1'b0;
            pnd_we_q    <= 1'b0;
            pnl_addr_q  <= '0;
            pnl_wdata_q <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            pnl_out_q   <= '0;
        end else begin
            op_q        <= op_d;
            last_q      <= last_d;
            pnd_q       <= pnd_d;
            pnd_we_q    <= pnd_we_d;
            pnl_addr_q  <= pnl_addr_d;
            pnl_wdata_q <= pnl_wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_out_q   <= pnl_out_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance at RD_LAT=1 with a scoreboard,
// one at RD_LAT=3 for latency and mid-access reset.
module tb_mem_access_ctrl;

    localparam int K_CR = 0;
    localparam int K_CW = 1;
    localparam int K_PA = 2;
    localparam int K_PW = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        pnl;
    } mexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RD_LAT=1 instance signals
    logic        rst_n, cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, pnl_sw, pnl_out;
    logic        pnl_btn_addr, pnl_btn_write, pnl_busy, mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    // RD_LAT=3 instance signals
    logic        rst_n3, cpu_req3, cpu_we3, cpu_ack3, cpu_rvalid3;
    logic [15:0] cpu_addr3, cpu_wdata3, cpu_rdata3, pnl_sw3, pnl_out3;
    logic        pnl_btn_addr3, pnl_btn_write3, pnl_busy3, mem_en3, mem_we3;
    logic [15:0] mem_addr3, mem_wdata3, mem_rdata3;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .pnl_sw(pnl_sw),
        .pnl_btn_addr(pnl_btn_addr), .pnl_btn_write(pnl_btn_write),
        .pnl_out(pnl_out), .pnl_busy(pnl_busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .cpu_req(cpu_req3), .cpu_we(cpu_we3),
        .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3), .cpu_ack(cpu_ack3),
        .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3), .pnl_sw(pnl_sw3),
        .pnl_btn_addr(pnl_btn_addr3), .pnl_btn_write(pnl_btn_write3),
        .pnl_out(pnl_out3), .pnl_busy(pnl_busy3), .mem_en(mem_en3), .mem_we(mem_we3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Memory models: 256 words, latency 1 and 3.
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] rd1, p0, p1, p2;
    logic        mem_init;

    function automatic logic [15:0] init_val(input int unsigned i);
        case (i)
            1:       return 16'h1234;
            2:       return 16'hAAAA;
            3:       return 16'h3C3C;
            7:       return 16'h7777;
            default: return {8'hA5, 8'(i)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_val(i);
                mem3[i] <= init_val(i);
            end
        end else begin
            if (mem_en) begin
                if (mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
                else        rd1 <= mem1[mem_addr[7:0]];
            end
            if (mem_en3) begin
                if (mem_we3) mem3[mem_addr3[7:0]] <= mem_wdata3;
                else         p0 <= mem3[mem_addr3[7:0]];
            end
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign mem_rdata  = rd1;
    assign mem_rdata3 = p2;

    int checks   = 0;
    int failures = 0;

    mexp_t       exp_mem_q [$];
    logic [15:0] exp_cpu_q [$];
    logic [15:0] exp_pnl_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=missing_or_extra required=expected_event", name);
    endtask

    task automatic push_mem(input logic we, input logic [15:0] a, input logic [15:0] d,
                            input logic pnl);
        mexp_t m;
        m.we = we; m.addr = a; m.wdata = d; m.pnl = pnl;
        exp_mem_q.push_back(m);
    endtask

    // Scoreboard monitor for the RD_LAT=1 instance.
    mexp_t       e_mon;
    logic [15:0] v_mon;
    logic        prev_en   = 1'b0;
    logic        prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (mem_en) begin
                chk("mem_en_back_to_back", 64'(prev_en), 64'd0);
                if (exp_mem_q.size() == 0) begin
                    miss("mem_en_unexpected");
                end else begin
                    e_mon = exp_mem_q.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(e_mon.we));
                    chk("mem_addr", 64'(mem_addr), 64'(e_mon.addr));
                    if (e_mon.we) chk("mem_wdata", 64'(mem_wdata), 64'(e_mon.wdata));
                    if (e_mon.pnl && e_mon.we)
                        chk("pnl_write_through", 64'(pnl_out), 64'(e_mon.wdata));
                end
            end
            if (cpu_rvalid) begin
                if (exp_cpu_q.size() == 0) begin
                    miss("cpu_rvalid_unexpected");
                end else begin
                    v_mon = exp_cpu_q.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(v_mon));
                end
            end
            if (prev_busy && !pnl_busy) begin
                if (exp_pnl_q.size() == 0) begin
                    miss("pnl_done_unexpected");
                end else begin
                    v_mon = exp_pnl_q.pop_front();
                    chk("pnl_out", 64'(pnl_out), 64'(v_mon));
                end
            end
            prev_en   = mem_en;
            prev_busy = pnl_busy;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_mem_q.size() + exp_cpu_q.size() + exp_pnl_q.size()) != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if ((exp_mem_q.size() + exp_cpu_q.size() + exp_pnl_q.size()) != 0) begin
            miss(name);
            exp_mem_q.delete();
            exp_cpu_q.delete();
            exp_pnl_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 20);
        if (!cpu_ack) miss("cpu_ack_timeout");
        @(posedge clk); #1;
        cpu_req = 1'b0;
        wait_drain("cpu_op_drain");
    endtask

    task automatic pnl_op(input logic is_write, input logic [15:0] sw);
        @(posedge clk); #1;
        pnl_sw = sw;
        if (is_write) pnl_btn_write = 1'b1;
        else          pnl_btn_addr  = 1'b1;
        @(posedge clk); #1;
        pnl_btn_write = 1'b0;
        pnl_btn_addr  = 1'b0;
        wait_drain("pnl_op_drain");
    endtask

    // Exact-cycle CPU read on the RD_LAT=3 instance.
    task automatic dut3_read(input logic [15:0] a, input logic [15:0] exp);
        @(posedge clk); #1;
        cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = a;
        @(negedge clk);
        chk("l3_c0_ack_en", 64'({cpu_ack3, mem_en3}), 64'd0);
        @(negedge clk);
        chk("l3_c1_ack_en", 64'({cpu_ack3, mem_en3}), 64'd3);
        @(posedge clk); #1;
        cpu_req3 = 1'b0;
        @(negedge clk);
        chk("l3_c2_rvalid_en", 64'({cpu_rvalid3, mem_en3}), 64'd0);
        @(negedge clk);
        chk("l3_c3_rvalid", 64'(cpu_rvalid3), 64'd0);
        @(negedge clk);
        chk("l3_c4_rvalid_data", 64'({cpu_rvalid3, cpu_rdata3}), 64'({1'b1, exp}));
        @(negedge clk);
        chk("l3_c5_rvalid", 64'(cpu_rvalid3), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [12];
    int   acks;
    int   n;
    logic rv_seen;

    initial begin
        tbl[0]  = '{K_PA, 16'h0001, 16'h0000, 16'h1234};
        tbl[1]  = '{K_PW, 16'h0001, 16'hF0F0, 16'hF0F0};
        tbl[2]  = '{K_PA, 16'h0001, 16'h0000, 16'hF0F0};
        tbl[3]  = '{K_CR, 16'h0002, 16'h0000, 16'hAAAA};
        tbl[4]  = '{K_CW, 16'h0005, 16'hBEEF, 16'h0000};
        tbl[5]  = '{K_CR, 16'h0005, 16'h0000, 16'hBEEF};
        tbl[6]  = '{K_PA, 16'h0005, 16'h0000, 16'hBEEF};
        tbl[7]  = '{K_PW, 16'h0005, 16'h0000, 16'h0000};
        tbl[8]  = '{K_CR, 16'h0005, 16'h0000, 16'h0000};
        tbl[9]  = '{K_CR, 16'h00FF, 16'h0000, 16'hA5FF};
        tbl[10] = '{K_CW, 16'h00FF, 16'hFFFF, 16'h0000};
        tbl[11] = '{K_PA, 16'h00FF, 16'h0000, 16'hFFFF};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pnl_sw = '0; pnl_btn_addr = 1'b0; pnl_btn_write = 1'b0;
        rst_n3 = 1'b0; cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        pnl_sw3 = '0; pnl_btn_addr3 = 1'b0; pnl_btn_write3 = 1'b0;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 64'({cpu_ack, cpu_rvalid, pnl_busy, mem_en, mem_we}), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_pnl_out", 64'(pnl_out), 64'd0);
        chk("rst_mem_addr_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("rst3_ctl", 64'({cpu_ack3, cpu_rvalid3, pnl_busy3, mem_en3, mem_we3}), 64'd0);
        mem_init = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n3 = 1'b1;

        // Contention right after reset: CPU, then PANEL, then CPU.
        push_mem(1'b0, 16'h0002, 16'h0000, 1'b0); exp_cpu_q.push_back(16'hAAAA);
        push_mem(1'b0, 16'h0007, 16'h0000, 1'b1); exp_pnl_q.push_back(16'h7777);
        push_mem(1'b0, 16'h0002, 16'h0000, 1'b0); exp_cpu_q.push_back(16'hAAAA);
        @(posedge clk); #1;
        pnl_sw = 16'h0007; pnl_btn_addr = 1'b1;
        @(posedge clk); #1;
        pnl_btn_addr = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        acks = 0; n = 0;
        while (acks < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (cpu_ack) acks++;
        end
        if (acks < 2) miss("arb_ack_timeout");
        @(posedge clk); #1;
        cpu_req = 1'b0;
        wait_drain("arb_drain");

        // Exact CPU read latency at RD_LAT=1.
        push_mem(1'b0, 16'h0002, 16'h0000, 1'b0); exp_cpu_q.push_back(16'hAAAA);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        @(negedge clk);
        chk("l1_c0_ack_en", 64'({cpu_ack, mem_en}), 64'd0);
        @(negedge clk);
        chk("l1_c1_ack_en", 64'({cpu_ack, mem_en, cpu_rvalid}), 64'd6);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("l1_c2_rvalid_data", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, 16'hAAAA}));
        @(negedge clk);
        chk("l1_c3_rvalid_hold", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b0, 16'hAAAA}));
        wait_drain("lat_drain");

        // Both buttons together: only the read of addr 3; write while busy dropped.
        push_mem(1'b0, 16'h0003, 16'h0000, 1'b1); exp_pnl_q.push_back(16'h3C3C);
        @(posedge clk); #1;
        pnl_sw = 16'h0003; pnl_btn_addr = 1'b1; pnl_btn_write = 1'b1;
        @(posedge clk); #1;
        pnl_btn_addr = 1'b0; pnl_btn_write = 1'b0;
        @(negedge clk);
        chk("simul_busy", 64'(pnl_busy), 64'd1);
        @(posedge clk); #1;
        pnl_sw = 16'h5555; pnl_btn_write = 1'b1;
        @(posedge clk); #1;
        pnl_btn_write = 1'b0;
        wait_drain("simul_drain");
        repeat (4) @(posedge clk);
        #1;
        chk("simul_idle", 64'({pnl_busy, pnl_out}), 64'({1'b0, 16'h3C3C}));

        // Table-driven transactions.
        for (int i = 0; i < 12; i++) begin
            case (tbl[i].kind)
                K_CR: begin
                    push_mem(1'b0, tbl[i].a, 16'h0000, 1'b0);
                    exp_cpu_q.push_back(tbl[i].exp);
                    cpu_op(1'b0, tbl[i].a, 16'h0000);
                end
                K_CW: begin
                    push_mem(1'b1, tbl[i].a, tbl[i].d, 1'b0);
                    cpu_op(1'b1, tbl[i].a, tbl[i].d);
                end
                K_PA: begin
                    push_mem(1'b0, tbl[i].a, 16'h0000, 1'b1);
                    exp_pnl_q.push_back(tbl[i].exp);
                    pnl_op(1'b0, tbl[i].a);
                end
                default: begin
                    push_mem(1'b1, tbl[i].a, tbl[i].d, 1'b1);
                    exp_pnl_q.push_back(tbl[i].exp);
                    pnl_op(1'b1, tbl[i].d);
                end
            endcase
        end

        // RD_LAT=3: normal read, reset during WAIT, then normal read again.
        dut3_read(16'h0001, 16'h1234);
        @(posedge clk); #1;
        cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 16'h0002;
        @(negedge clk);
        @(negedge clk);
        chk("r3_ack_before_reset", 64'(cpu_ack3), 64'd1);
        @(posedge clk); #1;
        cpu_req3 = 1'b0;
        #1;
        rst_n3 = 1'b0;
        #1;
        chk("r3_ctl_zero", 64'({cpu_ack3, cpu_rvalid3, pnl_busy3, mem_en3, mem_we3}), 64'd0);
        chk("r3_cpu_rdata_zero", 64'(cpu_rdata3), 64'd0);
        chk("r3_mem_addr_zero", 64'(mem_addr3), 64'd0);
        rv_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_rvalid3) rv_seen = 1'b1;
        end
        @(posedge clk); #1;
        rst_n3 = 1'b1;
        chk("r3_no_rvalid_in_reset", 64'(rv_seen), 64'd0);
        dut3_read(16'h0005, 16'hA505);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences a single-port, 16x16-class data memory and shares it between two requesters: a CPU load/store port and the board front panel (switches plus address and write buttons).
- Sits between the CPU/panel logic and the memory array and is the only block that drives the memory's enable, write-enable, address and write-data pins.
- Arbitrates round-robin, edge-detects the panel buttons and returns read data with a fixed latency.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- RD_LAT, 1, memory read latency in cycles, from the mem_en cycle to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high with cpu_we/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle pulse; request consumed.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data, held until the next CPU read completes.
- pnl_sw  in  DATA_W  switch bank; used as address or data.
- pnl_btn_addr  in  1  latch-address button (already synchronised and debounced).
- pnl_btn_write  in  1  write button (already synchronised and debounced).
- pnl_out  out  DATA_W  panel display value.
- pnl_busy  out  1  panel operation pending or in flight.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable (qualified by mem_en).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - State IDLE; pnl_addr register 0; panel pending flag clear.
  - Button history registers 0, so a button held high through reset release produces one edge in the first cycle.
  - Arbiter last-grant = PANEL, so the CPU wins the first contention.
- Panel edges: edge = btn & ~btn_q.
  - Addr edge: pnl_addr <= pnl_sw; sets pending panel READ at pnl_addr.
  - Write edge: captures pnl_sw as data; sets pending panel WRITE at the current pnl_addr.
  - Both edges in the same cycle: the addr edge wins and the write edge is dropped.
  - Any edge while pnl_busy=1 is ignored.
- pnl_busy is high from the cycle after the accepted edge until the panel operation completes.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if cpu_req or panel pending, grant and register the operation; go to ISSUE next cycle. If both are pending, grant the requester not granted last; otherwise grant the one that is pending.
  - ISSUE (exactly 1 cycle): mem_en=1, mem_we/addr/wdata from the granted operation. If the grant is CPU, cpu_ack=1. Writes go to IDLE. Reads go to WAIT if RD_LAT>1, else to DONE.
  - WAIT: count RD_LAT-1 cycles, then go to DONE.
  - DONE: capture mem_rdata. CPU: cpu_rdata <= mem_rdata, cpu_rvalid=1. Panel: pnl_out <= mem_rdata, clear pending. Go to IDLE.
- Panel write: pnl_out <= write data in the ISSUE cycle (write-through display); pending cleared in ISSUE.
- Latency, CPU read with req first seen in IDLE at cycle 0:
  - cpu_ack and mem_en at cycle 1.
  - cpu_rvalid at cycle 1+RD_LAT.
  - Next grant decided at cycle 2+RD_LAT.
- Latency, writes: ack at cycle 1, IDLE at cycle 2.
- mem_en is never high in two consecutive cycles.
- Outside ISSUE, mem_addr/mem_wdata/mem_we hold their last values and mem_en=0.
- cpu_req dropped before ack: no access is issued if it is low in IDLE. Dropping it after grant is a protocol violation, but the granted access completes.
- Reset mid-operation aborts immediately; the pending panel operation is lost and no rvalid is produced.

Decomposition:
- Package mem_ctrl_pkg:
  - State enum (IDLE/ISSUE/WAIT/DONE).
  - Grant encoding (GNT_CPU, GNT_PNL).
  - Op struct {we, addr, wdata, src}.
  - Default widths.
- One natural sub-module, btn_edge_detect: a 1-bit rising-edge detector with async active-low reset, instantiated twice.

Test Plan:
- Reset, then btn_addr pulse with sw=0x0001 while mem[1]=0x1234 -> pnl_addr=0x0001, one mem_en with we=0, pnl_out=0x1234 after RD_LAT+2 cycles, pnl_busy falls.
- Then sw=0xF0F0, btn_write pulse -> mem_en with we=1, addr=0x0001, wdata=0xF0F0; pnl_out=0xF0F0 in the ISSUE cycle; a subsequent btn_addr with sw=0x0001 reads back 0xF0F0.
- CPU read of addr 0x0002 (mem=0xAAAA), RD_LAT=1 -> cpu_ack at cycle 1, cpu_rvalid with cpu_rdata=0xAAAA at cycle 2, req dropped after ack.
- cpu_req held continuously while a panel read is pending -> grants alternate CPU, PANEL, CPU; the first grant after reset goes to CPU.
- btn_addr and btn_write rise in the same cycle (sw=0x0003) -> only a read of addr 3; no write issued. A second btn_write while pnl_busy=1 is ignored.
- rst_n asserted during WAIT (RD_LAT=3) -> all outputs 0 immediately, no cpu_rvalid; after release the FSM is in IDLE and serves the next request normally.
